// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pkg
// Description : Shared types and constants for the DSP run scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_pkg;

  localparam int DSP_DATA_W         = 12;
  localparam int DSP_RUN_CYCLES_DEF = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin pick over a request vector with a rotating
//               priority pointer that advances past each accepted winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             strobe,
  output logic             any,
  output logic [IDX_W-1:0] pick
);

  logic [IDX_W-1:0] ptr;

  // First pass covers indices at or above the pointer, second pass wraps.
  always_comb begin
    any  = 1'b0;
    pick = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
        any  = 1'b1;
        pick = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any  = 1'b1;
        pick = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (strobe && any) begin
      ptr <= (pick == IDX_W'(N - 1)) ? '0 : pick + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dsp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dsp_scheduler
// Description : Shares one DSP pipeline among N_REQ requesters; launches a run,
//               waits a fixed latency and returns the tagged result.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_scheduler
  import dsp_pkg::*;
#(
  parameter  int N_REQ      = 2,
  parameter  int RUN_CYCLES = DSP_RUN_CYCLES_DEF,
  parameter  int DATA_W     = DSP_DATA_W,
  localparam int TAG_W      = tag_w(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  input  logic              abort,
  output logic              dsp_ena,
  input  logic [DATA_W-1:0] solved,
  output logic [DATA_W-1:0] res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic [15:0]       run_cnt
);

  localparam logic [7:0] RUN_LOAD = 8'(RUN_CYCLES);

  state_t           state;
  logic [7:0]       cnt;
  logic [TAG_W-1:0] winner;
  logic             arb_any;
  logic [TAG_W-1:0] arb_pick;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (TAG_W)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .strobe (state == IDLE),
    .any    (arb_any),
    .pick   (arb_pick)
  );

  // The capture edge is the one on which cnt holds 1, which lands exactly
  // RUN_CYCLES edges after the launch edge loaded the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      winner    <= '0;
      gnt       <= '0;
      dsp_ena   <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      run_cnt   <= '0;
    end else begin
      gnt     <= '0;
      dsp_ena <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            winner <= arb_pick;
            state  <= LAUNCH;
            busy   <= 1'b1;
          end
        end
        LAUNCH: begin
          gnt[winner] <= 1'b1;
          dsp_ena     <= 1'b1;
          cnt         <= RUN_LOAD;
          state       <= abort ? DRAIN : WAIT;
        end
        WAIT: begin
          if (abort) begin
            cnt   <= (cnt == 8'd0) ? 8'd0 : cnt - 1'b1;
            state <= DRAIN;
          end else if (cnt <= 8'd1) begin
            cnt       <= '0;
            res_data  <= solved;
            res_tag   <= winner;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            run_cnt   <= run_cnt + 16'd1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (abort) begin
            res_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        DRAIN: begin
          // Let the pipeline empty before another launch can be issued.
          if (cnt <= 8'd1) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_scheduler
// Description : Directed self-checking bench for dsp_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_scheduler;

  localparam int N  = 2;
  localparam int R  = 24;
  localparam int DW = 12;
  localparam int TW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          abort;
  logic          dsp_ena;
  logic [DW-1:0] solved;
  logic [DW-1:0] res_data;
  logic [TW-1:0] res_tag;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic [15:0]   run_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  dsp_scheduler #(
    .N_REQ      (N),
    .RUN_CYCLES (R),
    .DATA_W     (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .abort     (abort),
    .dsp_ena   (dsp_ena),
    .solved    (solved),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .run_cnt   (run_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (gnt == '0 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check(tag, 32'(gnt != '0), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!res_valid && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check(tag, 32'(res_valid), 32'd1);
  endtask

  initial begin
    int n;
    int prev_cyc;
    int last_idx;

    rst = 1'b0; req = '0; abort = 1'b0; solved = '0; res_ready = 1'b0;
    step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ena", 32'(dsp_ena), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_tag", 32'(res_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_runcnt", 32'(run_cnt), 32'd0);
    rst = 1'b1;

    // Single run with hand-timed sample edge.
    req = 2'b01;
    step();
    check("launch_busy", 32'(busy), 32'd1);
    check("launch_gnt_lag", 32'(gnt), 32'd0);
    step();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_ena", 32'(dsp_ena), 32'd1);
    req = '0;
    step();
    check("ena_pulse", 32'(dsp_ena), 32'd0);
    check("gnt_pulse", 32'(gnt), 32'd0);
    repeat (R - 2) step();
    check("early_valid", 32'(res_valid), 32'd0);
    solved = 12'h5A3;
    step();
    solved = 12'h0F0;
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_data", 32'(res_data), 32'h5A3);
    check("single_tag", 32'(res_tag), 32'd0);
    check("single_cnt0", 32'(run_cnt), 32'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("single_done", 32'(res_valid), 32'd0);
    check("single_cnt1", 32'(run_cnt), 32'd1);
    check("single_idle", 32'(busy), 32'd0);

    // Fairness: both requesters held, consumer always ready.
    rst = 1'b0;
    step();
    rst = 1'b1;
    req = 2'b11; res_ready = 1'b1; solved = 12'h777;
    prev_cyc = 0; last_idx = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        step();
        n++;
        if (res_valid) check("fair_tag", 32'(res_tag), 32'(last_idx));
      end while (gnt == '0 && n < 300);
      if (n >= 300) check("fair_timeout", 32'(gnt != '0), 32'd1);
      check("fair_gnt", 32'(gnt), (g % 2 == 0) ? 32'h1 : 32'h2);
      if (g > 0) check("fair_period", 32'(cyc - prev_cyc), 32'(R + 3));
      prev_cyc = cyc;
      last_idx = g % 2;
      if (g == 3) req = '0;
    end
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    check("fair_idle", 32'(busy), 32'd0);
    check("fair_runcnt", 32'(run_cnt), 32'd4);

    // Backpressure: result held while solved wiggles and requester 1 waits.
    res_ready = 1'b0; solved = 12'h123; req = 2'b01;
    wait_gnt("bp_gnt_timeout");
    req = '0;
    wait_valid("bp_valid_timeout");
    req = 2'b10;
    for (int i = 0; i < 10; i++) begin
      solved = 12'(i * 37 + 5);
      step();
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_data", 32'(res_data), 32'h123);
      check("bp_tag", 32'(res_tag), 32'd0);
      check("bp_nognt", 32'(gnt), 32'd0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("bp_done", 32'(res_valid), 32'd0);
    check("bp_runcnt", 32'(run_cnt), 32'd5);
    step();
    check("bp_gnt_lag", 32'(gnt), 32'd0);
    step();
    check("bp_gnt", 32'(gnt), 32'h2);
    req = '0;

    // Abort while the counter holds 5.
    repeat (R - 5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_novalid", 32'(res_valid), 32'd0);
    repeat (3) step();
    check("drain_busy_late", 32'(busy), 32'd1);
    step();
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_novalid2", 32'(res_valid), 32'd0);
    check("drain_runcnt", 32'(run_cnt), 32'd5);
    req = 2'b01;
    step();
    step();
    check("post_abort_gnt", 32'(gnt), 32'h1);
    req = '0;

    // Abort together with ready in HOLD: transfer counts.
    solved = 12'h2B4;
    wait_valid("ar_valid_timeout");
    check("ar_data", 32'(res_data), 32'h2B4);
    abort = 1'b1; res_ready = 1'b1;
    step();
    abort = 1'b0; res_ready = 1'b0;
    check("ar_valid", 32'(res_valid), 32'd0);
    check("ar_runcnt", 32'(run_cnt), 32'd6);
    check("ar_idle", 32'(busy), 32'd0);

    // Abort alone in HOLD: result dropped, not counted.
    req = 2'b10;
    wait_gnt("ah_gnt_timeout");
    check("ah_gnt", 32'(gnt), 32'h2);
    req = '0; solved = 12'h3C3;
    wait_valid("ah_valid_timeout");
    check("ah_tag", 32'(res_tag), 32'd1);
    check("ah_data", 32'(res_data), 32'h3C3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ah_valid", 32'(res_valid), 32'd0);
    check("ah_idle", 32'(busy), 32'd0);
    check("ah_runcnt", 32'(run_cnt), 32'd6);

    // Asynchronous reset in the middle of WAIT.
    req = 2'b01;
    wait_gnt("rw_gnt_timeout");
    req = '0;
    repeat (5) step();
    check("rw_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_ena", 32'(dsp_ena), 32'd0);
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_data", 32'(res_data), 32'd0);
    check("arst_tag", 32'(res_tag), 32'd0);
    check("arst_runcnt", 32'(run_cnt), 32'd0);
    step();
    rst = 1'b1;
    req = 2'b11;
    step();
    step();
    check("arst_first_gnt", 32'(gnt), 32'h1);
    check("arst_first_ena", 32'(dsp_ena), 32'd1);
    req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dsp_scheduler.md
# dsp_scheduler

Round-robin scheduler that shares one DSP dot-product pipeline between N_REQ requesters. It grants one request at a time and launches the pipeline with a single-cycle `ena` pulse. After the pipeline's fixed run time it captures the 12-bit solved result and returns it, tagged with the requester index, over a valid/ready handshake. It sits directly above the DSP top level and owns that block's `ena` input.

## Interface
- `N_REQ`, 2: number of requesters, range 2..8.
- `RUN_CYCLES`, 24: cycles from the `dsp_ena` pulse to a stable `solved`; range 1..255.
- `DATA_W`, 12: result width; matches the DSP solved output.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester run request; level, held until the matching `gnt`.
- `gnt`  out  N_REQ  one-hot, single-cycle acceptance pulse.
- `abort`  in  1  cancels the current run; its result is discarded.
- `dsp_ena`  out  1  single-cycle start pulse to the DSP `ena`.
- `solved`  in  DATA_W  DSP result.
- `res_data`  out  DATA_W  captured result.
- `res_tag`  out  TAG_W = max(1, clog2(N_REQ))  index of the requester that owns `res_data`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high whenever the state is not IDLE.
- `run_cnt`  out  16  count of delivered results; wraps modulo 2^16.

## Operation
- Reset values: `gnt`=0, `dsp_ena`=0, `res_valid`=0, `res_data`=0, `res_tag`=0, `busy`=0, `run_cnt`=0, state=IDLE, priority pointer=0, wait counter=0.
- IDLE: if any `req` bit is set, pick the first set bit at or after the pointer, wrapping. Register the winner index, update the pointer to winner+1 (mod N_REQ), and go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH (1 cycle): `gnt[winner]`=1 and `dsp_ena`=1. Load the counter with RUN_CYCLES and go to WAIT.
- WAIT: decrement the counter each cycle.
  - When the counter reaches 0, capture `solved` into `res_data` and the winner into `res_tag`, set `res_valid`, and go to HOLD.
- HOLD: hold `res_data` and `res_tag` stable while `res_valid` && !`res_ready`.
  - On `res_valid` && `res_ready`: complete the transfer, clear `res_valid` on the next edge, increment `run_cnt`, and return to IDLE.
- DRAIN: entered on `abort` in LAUNCH or WAIT.
  - The counter keeps running to 0 so the DSP pipeline empties before the next launch.
  - No capture and no `run_cnt` increment; then go to IDLE.
- `abort` in HOLD without `res_ready`: clear `res_valid` on the next edge, return to IDLE, no increment.
- `abort` together with `res_ready` in HOLD: the transfer wins and is counted.
- `abort` in IDLE or DRAIN: ignored.
- A `req` bit dropped before its `gnt` is legal; it is only evaluated in IDLE.
- `req` from the winner held past `gnt` is treated as a new request.
- Only one run is ever in flight. The DSP never sees a second `ena` before the previous run drains.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- If `req` is sampled in IDLE at edge t, `gnt` and `dsp_ena` are high in the cycle after edge t+1.
- `solved` is sampled exactly RUN_CYCLES cycles after the `dsp_ena` cycle.
  - `res_valid` rises on that same edge, i.e. RUN_CYCLES+1 edges after LAUNCH began.
- Back-to-back throughput with `res_ready` tied high: one result every RUN_CYCLES+3 cycles.
- Asynchronous `rst` assertion mid-run: all outputs drop to reset values immediately, and any pending result is lost. The DSP must share the same reset so it is flushed too.

## Structure
- Package `dsp_pkg`:
  - state enum {IDLE, LAUNCH, WAIT, HOLD, DRAIN};
  - `DSP_DATA_W`=12;
  - `DSP_RUN_CYCLES_DEF`=24;
  - the TAG_W function.
- Sub-module `rr_arbiter`: combinational pick from `req` and the pointer, plus registered pointer update on the grant strobe. It is reusable for other shared resources.
- The top contains the FSM, the wait counter (8 bits), the result/tag registers and `run_cnt`.

## Test plan
- Single run: `req`=01, `solved` driven to 0x5A3 at the sample cycle. Expect `gnt`=01 with one `dsp_ena` pulse, then `res_valid` RUN_CYCLES+1 edges later with `res_data`=0x5A3, `res_tag`=0, and `run_cnt` going 0->1.
- Fairness: `req`=11 held continuously with `res_ready`=1. Expect grant sequence 0,1,0,1, `res_tag` alternating, and a period of RUN_CYCLES+3 cycles.
- Backpressure: `res_ready`=0 for 10 cycles while `solved` changes. Expect `res_data`/`res_tag` stable, `res_valid` held, no new `gnt` despite `req`=10. `gnt`=10 follows after `res_ready` rises.
- Abort in WAIT at counter=5: expect no `res_valid`, `busy` high until the drain completes, `run_cnt` unchanged. The next `req` is accepted afterwards.
- Corner cases: `abort` together with `res_ready` in HOLD counts the result (`run_cnt`+1). `rst` low mid-WAIT zeroes all outputs immediately, and the first run after reset grants requester 0.
